// File: rtl/csr_decoder_pkg.sv
// Shared types and index helpers for the CSR-to-dense feature map decoder.
package csr_decoder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ACT_ZERO = 2'd0,
        ACT_EMIT = 2'd1,
        ACT_SKIP = 2'd2
    } step_act_t;

    function automatic logic [31:0] raster_index(input logic [31:0] row, input logic [31:0] col,
                                                 input logic [31:0] side);
        return (row * side) + col;
    endfunction

    function automatic logic rc_in_range(input logic [31:0] row, input logic [31:0] col,
                                         input logic [31:0] side);
        return (row < side) && (col < side);
    endfunction

endpackage

// File: rtl/csr_decoder_entry_sel.sv
// Combinational selector: value, raster index and range flag of entry k of a flattened CSR map.
module csr_decoder_entry_sel
    import csr_decoder_pkg::*;
#(
    parameter int image_size         = 28,
    parameter int word_length        = 8,
    parameter int col_length         = 8,
    parameter int double_word_length = 16
) (
    input  logic [image_size*image_size*word_length-1:0] value_bus,
    input  logic [image_size*image_size*col_length-1:0]  col_bus,
    input  logic [image_size*image_size*col_length-1:0]  row_bus,
    input  logic [double_word_length-1:0]                k,
    output logic [word_length-1:0]                       value,
    output logic [double_word_length-1:0]                idx,
    output logic                                         in_range
);
    localparam int N2 = image_size * image_size;

    logic [31:0]           k_ext_s;
    logic [col_length-1:0] row_s;
    logic [col_length-1:0] col_s;

    assign k_ext_s = 32'(k);

    // Slice out entry k; a pointer past the map reads as an out-of-range entry.
    always_comb begin
        value = '0;
        row_s = '1;
        col_s = '1;
        if (k_ext_s < 32'(N2)) begin
            value = value_bus[k_ext_s*word_length +: word_length];
            row_s = row_bus[k_ext_s*col_length +: col_length];
            col_s = col_bus[k_ext_s*col_length +: col_length];
        end else begin
            value = '0;
        end
    end

    assign idx      = double_word_length'(raster_index(32'(row_s), 32'(col_s), 32'(image_size)));
    assign in_range = rc_in_range(32'(row_s), 32'(col_s), 32'(image_size));

endmodule

// File: rtl/csr_decoder.sv
// Replays one latched CSR feature map as a dense raster pixel stream with ready/valid flow control.
module csr_decoder
    import csr_decoder_pkg::*;
#(
    parameter int image_size         = 28,
    parameter int word_length        = 8,
    parameter int col_length         = 8,
    parameter int double_word_length = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [double_word_length-1:0]                valid_num,
    input  logic [image_size*image_size*word_length-1:0] in_value,
    input  logic [image_size*image_size*col_length-1:0]  in_cols,
    input  logic [image_size*image_size*col_length-1:0]  in_rows,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [word_length-1:0]                       out_data,
    output logic [col_length-1:0]                        out_row,
    output logic [col_length-1:0]                        out_col,
    output logic                                         out_last,
    output logic                                         err
);
    localparam int N2 = image_size * image_size;
    localparam logic [double_word_length-1:0] N2_DW  = double_word_length'(N2);
    localparam logic [double_word_length-1:0] ONE_DW = double_word_length'(1);
    localparam logic [col_length-1:0]         ONE_RC = col_length'(1);
    localparam logic [col_length-1:0]         LAST_RC = col_length'(image_size - 1);

    state_t    state_r, state_nxt;
    step_act_t act_s;

    logic [N2*word_length-1:0]      value_bus_r;
    logic [N2*col_length-1:0]       col_bus_r, row_bus_r;
    logic [double_word_length-1:0]  num_r, k_r, num_in_s, cur_num_s, cur_k_s;
    logic [double_word_length-1:0]  cur_idx_s, pos_idx_s, live_idx_s, held_idx_s;
    logic [col_length-1:0]          pos_row_r, pos_col_r, out_row_r, out_col_r;
    logic [word_length-1:0]         live_value_s, held_value_s, cur_value_s, out_data_r;
    logic live_in_range_s, held_in_range_s, cur_in_range_s;
    logic clamp_s, accept_s, step_en_s, last_xfer_s, pos_last_s;
    logic out_valid_r, out_last_r, err_r;

    // Entry 0 straight off the inputs lets the first beat leave on the accept edge.
    csr_decoder_entry_sel #(
        .image_size(image_size), .word_length(word_length),
        .col_length(col_length), .double_word_length(double_word_length)
    ) u_live_sel (
        .value_bus(in_value), .col_bus(in_cols), .row_bus(in_rows),
        .k({double_word_length{1'b0}}),
        .value(live_value_s), .idx(live_idx_s), .in_range(live_in_range_s)
    );

    csr_decoder_entry_sel #(
        .image_size(image_size), .word_length(word_length),
        .col_length(col_length), .double_word_length(double_word_length)
    ) u_held_sel (
        .value_bus(value_bus_r), .col_bus(col_bus_r), .row_bus(row_bus_r),
        .k(k_r),
        .value(held_value_s), .idx(held_idx_s), .in_range(held_in_range_s)
    );

    assign clamp_s    = 32'(valid_num) > 32'(N2);
    assign num_in_s   = clamp_s ? N2_DW : valid_num;
    assign pos_idx_s  = double_word_length'(raster_index(32'(pos_row_r), 32'(pos_col_r), 32'(image_size)));
    assign pos_last_s = (pos_row_r == LAST_RC) && (pos_col_r == LAST_RC);

    // Next state, step enable and the per-step decision (emit / zero / skip).
    always_comb begin
        state_nxt   = state_r;
        accept_s    = 1'b0;
        step_en_s   = 1'b0;
        last_xfer_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s  = 1'b1;
                    step_en_s = 1'b1;
                    state_nxt = ST_STREAM;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                last_xfer_s = out_valid_r && out_ready && out_last_r;
                if (last_xfer_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step_en_s = !(out_valid_r && out_last_r) && (!out_valid_r || out_ready);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state_r == ST_IDLE) begin
            cur_num_s      = num_in_s;
            cur_k_s        = '0;
            cur_value_s    = live_value_s;
            cur_idx_s      = live_idx_s;
            cur_in_range_s = live_in_range_s;
        end else begin
            cur_num_s      = num_r;
            cur_k_s        = k_r;
            cur_value_s    = held_value_s;
            cur_idx_s      = held_idx_s;
            cur_in_range_s = held_in_range_s;
        end

        act_s = ACT_ZERO;
        if ((cur_k_s < cur_num_s) && cur_in_range_s) begin
            if (cur_idx_s == pos_idx_s) begin
                act_s = ACT_EMIT;
            end else if (cur_idx_s < pos_idx_s) begin
                act_s = ACT_SKIP;
            end else begin
                act_s = ACT_ZERO;
            end
        end else begin
            act_s = ACT_ZERO;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Map capture, position/entry counters, output beat register and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_bus_r <= '0;
            col_bus_r   <= '0;
            row_bus_r   <= '0;
            num_r       <= '0;
            k_r         <= '0;
            pos_row_r   <= '0;
            pos_col_r   <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_row_r   <= '0;
            out_col_r   <= '0;
            out_last_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                value_bus_r <= in_value;
                col_bus_r   <= in_cols;
                row_bus_r   <= in_rows;
                num_r       <= num_in_s;
                err_r       <= clamp_s;
            end else if ((last_xfer_s && (k_r < num_r)) || (step_en_s && (act_s == ACT_SKIP))) begin
                err_r <= 1'b1;
            end

            if (step_en_s) begin
                if (act_s == ACT_SKIP) begin
                    out_valid_r <= 1'b0;
                end else begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= (act_s == ACT_EMIT) ? cur_value_s : '0;
                    out_row_r   <= pos_row_r;
                    out_col_r   <= pos_col_r;
                    out_last_r  <= pos_last_s;
                    if (pos_col_r == LAST_RC) begin
                        pos_col_r <= '0;
                        pos_row_r <= pos_last_s ? '0 : pos_row_r + ONE_RC;
                    end else begin
                        pos_col_r <= pos_col_r + ONE_RC;
                    end
                end
                k_r <= (act_s == ACT_ZERO) ? cur_k_s : cur_k_s + ONE_DW;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_row   = out_row_r;
    assign out_col   = out_col_r;
    assign out_last  = out_last_r;
    assign err       = err_r;

endmodule

// File: tb/tb_csr_decoder.sv
// Directed and randomized bench for csr_decoder against a dense-map reference model.
module tb_csr_decoder;
    localparam int N  = 28;
    localparam int N2 = N * N;
    localparam int W  = 8;
    localparam int CL = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_last, err;
    logic [DW-1:0]      valid_num = '0;
    logic [N2*W-1:0]    in_value  = '0;
    logic [N2*CL-1:0]   in_cols   = '0;
    logic [N2*CL-1:0]   in_rows   = '0;
    logic [W-1:0]       out_data;
    logic [CL-1:0]      out_row, out_col;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] ent_val [N2];
    int         ent_row [N2];
    int         ent_col [N2];
    int         n_ent;
    int         num;
    logic [7:0] exp_data [N2];
    logic       exp_err;
    int         exp_skips;

    csr_decoder #(
        .image_size(N), .word_length(W), .col_length(CL), .double_word_length(DW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .valid_num(valid_num), .in_value(in_value), .in_cols(in_cols), .in_rows(in_rows),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_map();
        n_ent = 0;
        num   = 0;
        for (int k = 0; k < N2; k++) begin
            ent_val[k] = 8'($urandom);
            ent_row[k] = $urandom_range(0, 255);
            ent_col[k] = $urandom_range(0, 255);
        end
    endtask

    task automatic add_entry(input int r, input int c, input logic [7:0] v);
        ent_row[n_ent] = r;
        ent_col[n_ent] = c;
        ent_val[n_ent] = v;
        n_ent++;
        num = n_ent;
    endtask

    task automatic rand_fill(input int density);
        for (int p = 0; p < N2; p++) begin
            if ($urandom_range(0, 99) < density) add_entry(p / N, p % N, 8'($urandom_range(0, 255)));
        end
    endtask

    // Reference: walk every raster position, consuming the sorted entry list.
    task automatic compute_model();
        int eff, k;
        eff       = (num > N2) ? N2 : num;
        exp_err   = (num > N2);
        exp_skips = 0;
        k         = 0;
        for (int p = 0; p < N2; p++) begin
            exp_data[p] = 8'h00;
            while (k < eff && ent_row[k] < N && ent_col[k] < N && ent_row[k] * N + ent_col[k] < p) begin
                exp_err = 1'b1;
                exp_skips++;
                k++;
            end
            if (k < eff && ent_row[k] < N && ent_col[k] < N && ent_row[k] * N + ent_col[k] == p) begin
                exp_data[p] = ent_val[k];
                k++;
            end
        end
        if (k < eff) exp_err = 1'b1;
    endtask

    task automatic send_map(input string tag);
        compute_model();
        @(negedge clk);
        chk({tag, " in_ready idle"}, 64'(in_ready), 64'(1'b1));
        for (int k = 0; k < N2; k++) begin
            in_value[k*W +: W]  = ent_val[k];
            in_rows[k*CL +: CL] = 8'(ent_row[k]);
            in_cols[k*CL +: CL] = 8'(ent_col[k]);
        end
        valid_num = DW'(num);
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        valid_num = DW'($urandom);
        for (int i = 0; i < N2 * W / 32; i++) begin
            in_value[i*32 +: 32] = $urandom;
            in_rows[i*32 +: 32]  = $urandom;
            in_cols[i*32 +: 32]  = $urandom;
        end
        chk({tag, " in_ready busy"}, 64'(in_ready), 64'(1'b0));
        chk({tag, " first valid"}, 64'(out_valid), 64'(1'b1));
    endtask

    task automatic drain(input string tag, input bit rnd, input bit noise, input int stop_at,
                         output int cycles);
        int beat;
        bit done, stalled;
        logic [25:0] held, now;
        beat = 0; done = 1'b0; stalled = 1'b0; held = '0; cycles = 0;
        while (!done && cycles < 8 * N2) begin
            @(negedge clk);
            cycles++;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            now = {out_valid, out_row, out_col, out_data, out_last};
            if (stalled) chk({tag, " stall hold"}, 64'(now), 64'(held));
            if (out_valid && out_ready) begin
                chk({tag, " beat"}, 64'({out_row, out_col, out_data, out_last}),
                    64'({8'(beat / N), 8'(beat % N), exp_data[beat], beat == N2 - 1}));
                beat++;
                if (out_last || beat == N2 || beat == stop_at) done = 1'b1;
            end
            stalled  = out_valid && !out_ready;
            held     = now;
            in_valid = (noise && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (!done) chk({tag, " timeout"}, 64'(1'b0), 64'(1'b1));
    endtask

    task automatic run_map(input string tag, input bit rnd, input bit noise);
        int cyc;
        send_map(tag);
        drain(tag, rnd, noise, N2, cyc);
        @(posedge clk);
        #1;
        chk({tag, " in_ready after"}, 64'(in_ready), 64'(1'b1));
        chk({tag, " valid after"}, 64'(out_valid), 64'(1'b0));
        chk({tag, " err"}, 64'(err), 64'(exp_err));
        if (!rnd) chk({tag, " cycles"}, 64'(cyc), 64'(N2 + exp_skips));
    endtask

    initial begin
        int cyc;
        #12;
        chk("reset outputs", 64'({in_ready, out_valid, out_data, out_row, out_col, out_last, err}),
            64'({1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle outputs", 64'({in_ready, out_valid, out_last, err}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));

        clear_map(); add_entry(0, 1, 8'd5); add_entry(2, 3, 8'd9);
        run_map("sparse", 1'b0, 1'b0);

        clear_map();
        run_map("empty", 1'b0, 1'b0);

        clear_map(); rand_fill(10);
        run_map("rand_r1", 1'b0, 1'b0);
        run_map("rand_stall", 1'b1, 1'b1);

        clear_map(); add_entry(5, 5, 8'd0); add_entry(27, 26, 8'd7); add_entry(27, 27, 8'd0);
        run_map("zero_val", 1'b0, 1'b0);

        clear_map(); add_entry(1, 1, 8'd3); add_entry(0, 2, 8'd4);
        run_map("skip", 1'b0, 1'b0);

        clear_map(); add_entry(0, 3, 8'd6); add_entry(30, 2, 8'd8); add_entry(4, 4, 8'd1);
        run_map("row_oor", 1'b0, 1'b0);

        clear_map();
        for (int p = 0; p < N2; p++) add_entry(p / N, p % N, 8'(p * 7 + 1));
        num = 900;
        run_map("clamp", 1'b1, 1'b0);

        clear_map(); rand_fill(15);
        if (n_ent > 6) begin
            ent_row[2] = ent_row[5];
            ent_col[2] = ent_col[5];
        end
        run_map("rand_bad", 1'b1, 1'b0);

        clear_map();
        for (int p = 0; p < N2; p++) add_entry(p / N, p % N, 8'(p + 3));
        num = 900;
        send_map("rst_mid");
        drain("rst_mid", 1'b0, 1'b0, 100, cyc);
        chk("rst_mid err before", 64'(err), 64'(1'b1));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid outputs", 64'({in_ready, out_valid, out_data, out_row, out_col, out_last, err}),
            64'({1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;

        clear_map(); rand_fill(20);
        run_map("post_rst", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
